// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory port arbiter: word size, FSM encoding,
// owner encoding and counter width.
package mem_arb_pkg;

   // Default address/data width, matching the datapath word size.
   localparam int WORD_SIZE = 16;

   // Width of the latency and starvation counters (LATENCY, STARVE_LIMIT <= 15).
   localparam int CNT_W = 4;

   // FSM encoding, kept as plain constants for compatibility with legacy code.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   // Transaction owner encoding, as reported on owner_d.
   localparam logic OWNER_I = 1'b0;
   localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the arbiter.
// master: the arbiter itself. slave: the pipeline requesters plus memory model.
interface mem_port_arbiter_if #(
   parameter int WORD_SIZE = mem_arb_pkg::WORD_SIZE
);
   // Fetch requester
   logic                 i_req;
   logic [WORD_SIZE-1:0] i_addr;
   logic [WORD_SIZE-1:0] i_rdata;
   logic                 i_ready;
   // Data requester
   logic                 d_read;
   logic                 d_write;
   logic [WORD_SIZE-1:0] d_addr;
   logic [WORD_SIZE-1:0] d_wdata;
   logic [WORD_SIZE-1:0] d_rdata;
   logic                 d_ready;
   // Memory port
   logic                 m_read;
   logic                 m_write;
   logic [WORD_SIZE-1:0] m_addr;
   logic [WORD_SIZE-1:0] m_wdata;
   logic [WORD_SIZE-1:0] m_rdata;
   // Status
   logic                 busy;
   logic                 owner_d;
   logic                 proto_err;

   modport master (
      input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata,
      output i_rdata, i_ready, d_rdata, d_ready,
             m_read, m_write, m_addr, m_wdata, busy, owner_d, proto_err
   );

   modport slave (
      output i_req, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata,
      input  i_rdata, i_ready, d_rdata, d_ready,
             m_read, m_write, m_addr, m_wdata, busy, owner_d, proto_err
   );

endinterface

// File: rtl/arb_starve_counter.sv
// Saturating loss counter for arbitration fairness: counts up on inc_i,
// holds at LIMIT, clears on clr_i (clear wins).
module arb_starve_counter #(
   parameter int LIMIT = 4,
   parameter int CNT_W = mem_arb_pkg::CNT_W
) (
   input  logic clk,
   input  logic reset_n,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_limit_o
);

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear has priority, increment saturates at LIMIT.
   always_comb begin
      // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned (no latch).
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != LIMIT_C)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state is written with non-blocking assignments only.
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between instruction fetch and the
// data stage. Data has fixed priority; after STARVE_LIMIT consecutive losses
// fetch is forced through. Each transaction: latch request, strobe the memory
// for LATENCY cycles, capture read data, pulse the owner's ready for one cycle.
module mem_port_arbiter #(
   parameter int WORD_SIZE    = mem_arb_pkg::WORD_SIZE,
   parameter int LATENCY      = 3,
   parameter int STARVE_LIMIT = 4
) (
   input logic                clk,
   input logic                reset_n,
   mem_port_arbiter_if.master bus
);
   import mem_arb_pkg::*;

   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

   logic [1:0]           state_q,   state_d;
   logic [CNT_W-1:0]     cnt_q,     cnt_d;
   logic [WORD_SIZE-1:0] addr_q,    addr_d;
   logic [WORD_SIZE-1:0] wdata_q,   wdata_d;
   logic                 wr_q,      wr_d;
   logic                 owner_q,   owner_d;
   logic                 perr_q,    perr_d;
   logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
   logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;

   logic d_any;
   logic at_limit;
   logic grant_i;
   logic grant_d;
   logic in_access;

   assign d_any     = bus.d_read | bus.d_write;
   assign in_access = (state_q == ST_ACCESS);

   // Arbitration in IDLE: starved fetch first, then data, then fetch.
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (state_q == ST_IDLE) begin
         if (at_limit && bus.i_req) begin
            grant_i = 1'b1;
         end else if (d_any) begin
            grant_d = 1'b1;
         end else if (bus.i_req) begin
            grant_i = 1'b1;
         end
      end
   end

   // Counts data grants that made a waiting fetch lose; any fetch grant clears it.
   arb_starve_counter #(
      .LIMIT (STARVE_LIMIT),
      .CNT_W (CNT_W)
   ) u_starve (
      .clk        (clk),
      .reset_n    (reset_n),
      .inc_i      (grant_d & bus.i_req),
      .clr_i      (grant_i),
      .at_limit_o (at_limit)
   );

   // FSM next state, request latching and read-data capture.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_d      = wr_q;
      owner_d   = owner_q;
      perr_d    = perr_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_d) begin
               // A simultaneous read+write executes as a write and is flagged.
               addr_d  = bus.d_addr;
               wdata_d = bus.d_wdata;
               wr_d    = bus.d_write;
               owner_d = OWNER_D;
               perr_d  = perr_q | (bus.d_read & bus.d_write);
               cnt_d   = LAT_LOAD;
               state_d = ST_ACCESS;
            end else if (grant_i) begin
               addr_d  = bus.i_addr;
               wdata_d = '0;
               wr_d    = 1'b0;
               owner_d = OWNER_I;
               cnt_d   = LAT_LOAD;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               if (!wr_q) begin
                  if (owner_q == OWNER_D) begin
                     d_rdata_d = bus.m_rdata;
                  end else begin
                     i_rdata_d = bus.m_rdata;
                  end
               end
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; asynchronous reset aborts any transaction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: these are a handful of flops, not a memory array, so all of them are reset; outputs must read 0 in reset.
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         owner_q   <= OWNER_I;
         perr_q    <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wr_q      <= wr_d;
         owner_q   <= owner_d;
         perr_q    <= perr_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   // Memory strobes come straight from state so reset drops them immediately;
   // address/data are forced to 0 whenever the port is idle.
   assign bus.m_read    = in_access & ~wr_q;
   assign bus.m_write   = in_access &  wr_q;
   assign bus.m_addr    = in_access ? addr_q : '0;
   assign bus.m_wdata   = (in_access & wr_q) ? wdata_q : '0;

   assign bus.i_ready   = (state_q == ST_RESP) & (owner_q == OWNER_I);
   assign bus.d_ready   = (state_q == ST_RESP) & (owner_q == OWNER_D);
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.owner_d   = owner_q;
   assign bus.proto_err = perr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected transactions,
// a monitor pops and compares them on every ready pulse.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int LAT  = 3;
   localparam int SLIM = 4;
   localparam int W    = 16;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.WORD_SIZE(W)) bus ();

   mem_port_arbiter #(
      .WORD_SIZE    (W),
      .LATENCY      (LAT),
      .STARVE_LIMIT (SLIM)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // ---------------- memory model ----------------
   logic [W-1:0] wmem    [256];
   bit           written [256];

   function automatic logic [W-1:0] rom(input logic [7:0] a);
      case (a)
         8'h10:   return 16'hA5A5;
         8'h00:   return 16'hBEEF;
         8'h20:   return 16'h1357;
         default: return {8'hC3, a};
      endcase
   endfunction

   always @(posedge clk) begin
      if (bus.m_write) begin
         wmem[bus.m_addr[7:0]]    <= bus.m_wdata;
         written[bus.m_addr[7:0]] <= 1'b1;
      end
   end

   always_comb begin
      bus.m_rdata = '0;
      if (bus.m_read) begin
         bus.m_rdata = written[bus.m_addr[7:0]] ? wmem[bus.m_addr[7:0]] : rom(bus.m_addr[7:0]);
      end
   end

   // ---------------- bookkeeping ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] all_outs();
      logic [127:0] r;
      r = '0;
      r[70:0] = {bus.i_rdata, bus.d_rdata, bus.m_addr, bus.m_wdata, bus.i_ready, bus.d_ready,
                 bus.m_read, bus.m_write, bus.busy, bus.owner_d, bus.proto_err};
      return r;
   endfunction

   typedef struct {
      bit           own_d;
      bit           wr;
      logic [W-1:0] addr;
      logic [W-1:0] wdata;
      logic [W-1:0] rdata;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] d_model = '0;

   task automatic push_i(input logic [W-1:0] a, input logic [W-1:0] rd);
      exp_t e;
      e = '{own_d: 1'b0, wr: 1'b0, addr: a, wdata: '0, rdata: rd};
      sb.push_back(e);
   endtask

   task automatic push_d_rd(input logic [W-1:0] a, input logic [W-1:0] rd);
      exp_t e;
      e = '{own_d: 1'b1, wr: 1'b0, addr: a, wdata: '0, rdata: rd};
      sb.push_back(e);
      d_model = rd;
   endtask

   task automatic push_d_wr(input logic [W-1:0] a, input logic [W-1:0] wd);
      exp_t e;
      e = '{own_d: 1'b1, wr: 1'b1, addr: a, wdata: wd, rdata: d_model};
      sb.push_back(e);
   endtask

   // ---------------- monitor ----------------
   int           strobe_n = 0;
   logic [W-1:0] s_addr   = '0;
   logic [W-1:0] s_wdata  = '0;
   bit           s_wr     = 1'b0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            strobe_n = 0;
         end else begin
            check("ready_exclusive", bus.i_ready & bus.d_ready, 1'b0);
            check("strobe_exclusive", bus.m_read & bus.m_write, 1'b0);
            if (bus.m_read | bus.m_write) begin
               strobe_n++;
               s_addr  = bus.m_addr;
               s_wdata = bus.m_wdata;
               s_wr    = bus.m_write;
            end else begin
               check("idle_bus_zero", {bus.m_addr, bus.m_wdata}, '0);
            end
            if (bus.i_ready | bus.d_ready) begin
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_ready: i_ready=%0b d_ready=%0b with nothing outstanding",
                           bus.i_ready, bus.d_ready);
               end else begin
                  e = sb.pop_front();
                  check("owner", bus.d_ready, e.own_d);
                  check("strobe_cycles", strobe_n, LAT);
                  check("mem_addr", s_addr, e.addr);
                  check("mem_op_write", s_wr, e.wr);
                  if (e.wr) check("mem_wdata", s_wdata, e.wdata);
                  if (e.own_d) check("d_rdata", bus.d_rdata, e.rdata);
                  else         check("i_rdata", bus.i_rdata, e.rdata);
               end
               strobe_n = 0;
            end
         end
      end
   end

   // ---------------- requester helpers ----------------
   int cyc, i_at, d_at, i_first, i_seen, d_seen;
   bit i_keep = 1'b0;
   bit d_keep = 1'b0;

   task automatic start_scn();
      cyc = 0; i_at = 0; d_at = 0; i_first = 0; i_seen = 0; d_seen = 0;
   endtask

   // One cycle: observe readies at negedge, then apply the drop-after-ready rule.
   task automatic tick();
      bit ir, dr;
      @(negedge clk);
      cyc++;
      ir = bus.i_ready;
      dr = bus.d_ready;
      if (ir) begin
         i_at = cyc;
         i_seen++;
         if (i_seen == 1) i_first = cyc;
      end
      if (dr) begin
         d_at = cyc;
         d_seen++;
      end
      @(posedge clk);
      #1;
      if (ir && !i_keep) bus.i_req = 1'b0;
      if (dr && !d_keep) begin
         bus.d_read  = 1'b0;
         bus.d_write = 1'b0;
      end
   endtask

   task automatic run_until(input int ni, input int nd, input int budget, input string name);
      int k;
      k = 0;
      while ((i_seen < ni || d_seen < nd) && k < budget) begin
         tick();
         k++;
      end
      if (i_seen < ni || d_seen < nd) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: i_ready %0d of %0d, d_ready %0d of %0d", name, i_seen, ni, d_seen, nd);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_n     = 1'b0;
      bus.i_req   = 1'b0;
      bus.i_addr  = '0;
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", all_outs(), '0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Single fetch
      start_scn();
      bus.i_addr = 16'h0010;
      bus.i_req  = 1'b1;
      push_i(16'h0010, 16'hA5A5);
      run_until(1, 0, 20, "single_fetch");
      check("fetch_ready_cycle", i_at, 5);
      check("fetch_owner_d", bus.owner_d, 1'b0);
      check("fetch_rdata_held", bus.i_rdata, 16'hA5A5);
      check("fetch_busy_after", bus.busy, 1'b0);

      // Simultaneous fetch + data read: data first
      start_scn();
      bus.i_addr = 16'h0020;
      bus.d_addr = 16'h0100;
      bus.i_req  = 1'b1;
      bus.d_read = 1'b1;
      push_d_rd(16'h0100, 16'hBEEF);
      push_i(16'h0020, 16'h1357);
      run_until(1, 1, 30, "simultaneous");
      check("simul_d_ready_cycle", d_at, 5);
      check("simul_i_ready_cycle", i_at, 10);

      // Data write
      start_scn();
      bus.d_addr  = 16'h0042;
      bus.d_wdata = 16'h1234;
      bus.d_write = 1'b1;
      push_d_wr(16'h0042, 16'h1234);
      run_until(0, 1, 20, "data_write");
      check("write_ready_cycle", d_at, 5);
      check("write_d_rdata_kept", bus.d_rdata, 16'hBEEF);
      check("write_owner_d", bus.owner_d, 1'b1);

      // Read back the written word
      start_scn();
      bus.d_addr = 16'h0042;
      bus.d_read = 1'b1;
      push_d_rd(16'h0042, 16'h1234);
      run_until(0, 1, 20, "read_back");
      check("readback_rdata", bus.d_rdata, 16'h1234);

      // Starvation: both held, pattern is 4 data grants then one fetch
      start_scn();
      i_keep     = 1'b1;
      d_keep     = 1'b1;
      bus.i_addr = 16'h0020;
      bus.d_addr = 16'h0100;
      bus.i_req  = 1'b1;
      bus.d_read = 1'b1;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < SLIM; k++) push_d_rd(16'h0100, 16'hBEEF);
         push_i(16'h0020, 16'h1357);
      end
      run_until(2, 2 * SLIM, 80, "starvation");
      bus.i_req  = 1'b0;
      bus.d_read = 1'b0;
      i_keep     = 1'b0;
      d_keep     = 1'b0;
      check("starve_first_i", i_first, 25);
      check("starve_second_i", i_at, 50);
      check("starve_d_count", d_seen, 2 * SLIM);
      check("starve_i_count", i_seen, 2);

      // Protocol error: read and write together executes as a write
      check("proto_err_before", bus.proto_err, 1'b0);
      start_scn();
      bus.d_addr  = 16'h0055;
      bus.d_wdata = 16'h7777;
      bus.d_read  = 1'b1;
      bus.d_write = 1'b1;
      push_d_wr(16'h0055, 16'h7777);
      run_until(0, 1, 20, "proto_err");
      check("proto_err_set", bus.proto_err, 1'b1);
      start_scn();
      bus.i_addr = 16'h0010;
      bus.i_req  = 1'b1;
      push_i(16'h0010, 16'hA5A5);
      run_until(1, 0, 20, "proto_err_follow");
      check("proto_err_sticky", bus.proto_err, 1'b1);

      // Reset in the second strobe cycle of a fetch
      bus.i_addr = 16'h0030;
      bus.i_req  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("abort_strobe_c1", bus.m_read, 1'b1);
      @(posedge clk);
      #1;
      check("abort_strobe_c2", bus.m_read, 1'b1);
      reset_n = 1'b0;
      #1;
      check("abort_outputs_now", all_outs(), '0);
      bus.i_req = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_outputs_held", all_outs(), '0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      d_model = '0;

      // Fresh fetch after reset
      start_scn();
      bus.i_addr = 16'h0010;
      bus.i_req  = 1'b1;
      push_i(16'h0010, 16'hA5A5);
      run_until(1, 0, 20, "post_reset_fetch");
      check("post_reset_ready_cycle", i_at, 5);
      check("post_reset_rdata", bus.i_rdata, 16'hA5A5);

      repeat (2) tick();
      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time bound, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

endmodule
